// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, ALU operations, mux selects and condition-code evaluation.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
    ALU_ORR = 3'b011, ALU_EOR = 3'b100
  } alu_op_e;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100, CMD_SUB = 4'b0010, CMD_AND = 4'b0000,
                         CMD_ORR = 4'b1100, CMD_EOR = 4'b0001, CMD_CMP = 4'b1010,
                         CMD_TST = 4'b1000;

  localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010,
                         COND_CC = 4'b0011, COND_MI = 4'b0100, COND_PL = 4'b0101,
                         COND_VS = 4'b0110, COND_VC = 4'b0111, COND_HI = 4'b1000,
                         COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
                         COND_GT = 4'b1100, COND_LE = 4'b1101;

  // nzcv is ordered {N,Z,C,V}; AL and the 1111 code both evaluate as always.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n ~^ v;
      COND_LT: return n ^ v;
      COND_GT: return ~z & (n ~^ v);
      COND_LE: return z | (n ^ v);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controlunit_if.sv
// Instruction/flag inputs and datapath strobes of the multicycle control unit.
// The master side is the control unit, the slave side is the datapath.
interface multicycle_controlunit_if #(parameter int ALUCTRL_W = 3);
    logic [31:0]          Instr;
    logic [3:0]           Flags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic                 RegWrite;

    modport master (
        input  Instr, Flags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );

    modport slave (
        output Instr, Flags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );
endinterface

// File: rtl/multicycle_controlunit_cond_unit.sv
// Holds the N,Z,C,V status register and evaluates the instruction condition
// against it; updates are gated by the instruction's own CondEx.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    input  logic [1:0] FlagW,
    input  logic       flag_we,
    output logic       CondEx
);
    logic [3:0] flags_q, flags_d;

    assign CondEx = cond_eval(Cond, flags_q);

    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        flags_d = flags_q;
        if (flag_we && CondEx) begin
            if (FlagW[1]) flags_d[3:2] = Flags[3:2];
            if (FlagW[0]) flags_d[1:0] = Flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments only.
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end
endmodule

// File: rtl/multicycle_controlunit.sv
// Moore FSM control unit for the multicycle ARM datapath with memory wait states.
// Define CTRL_CMP_TST_EN to decode CMP/TST (flag-only ops that skip ALUWB).
module multicycle_controlunit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_WAIT  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controlunit_if.master bus
);
`ifdef CTRL_CMP_TST_EN
    localparam bit CMP_TST_EN = 1'b1;
`else
    localparam bit CMP_TST_EN = 1'b0;
`endif
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;

    assign op    = bus.Instr[27:26];
    assign funct = bus.Instr[25:20];
    assign rd    = bus.Instr[15:12];

    // Data-processing decode; unknown codes fall back to ADD without flag write.
    alu_op_e    dp_op;
    logic [1:0] dp_flagw;
    logic       dp_no_wb;

    always_comb begin
        dp_op    = ALU_ADD;
        dp_flagw = 2'b00;
        dp_no_wb = 1'b0;
        case (funct[4:1])
            CMD_ADD: begin dp_op = ALU_ADD; dp_flagw = {2{funct[0]}};    end
            CMD_SUB: begin dp_op = ALU_SUB; dp_flagw = {2{funct[0]}};    end
            CMD_AND: begin dp_op = ALU_AND; dp_flagw = {funct[0], 1'b0}; end
            CMD_ORR: begin dp_op = ALU_ORR; dp_flagw = {funct[0], 1'b0}; end
            CMD_EOR: if (ALUCTRL_W >= 3) begin
                dp_op = ALU_EOR; dp_flagw = {funct[0], 1'b0};
            end
            CMD_CMP: if (CMP_TST_EN && funct[0]) begin
                dp_op = ALU_SUB; dp_flagw = 2'b11; dp_no_wb = 1'b1;
            end
            CMD_TST: if (CMP_TST_EN && funct[0]) begin
                dp_op = ALU_AND; dp_flagw = 2'b10; dp_no_wb = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH:
                if (wait_q == WAIT_LAST) state_d = S_DECODE;
                else                     wait_d  = wait_q + 4'd1;
            S_DECODE:
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            S_MEMADR:  state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:
                if (wait_q == WAIT_LAST) state_d = S_MEMWB;
                else                     wait_d  = wait_q + 4'd1;
            S_EXECUTER, S_EXECUTEI: state_d = dp_no_wb ? S_FETCH : S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    logic       pc_upd, adr_src, mem_w, ir_write, alu_src_a, reg_w, branch, flag_we;
    logic [1:0] result_src, alu_src_b;
    alu_op_e    alu_sel;

    always_comb begin
        pc_upd = 1'b0; adr_src = 1'b0; mem_w = 1'b0; ir_write = 1'b0;
        alu_src_a = 1'b0; reg_w = 1'b0; branch = 1'b0; flag_we = 1'b0;
        result_src = RES_ALUOUT; alu_src_b = SRCB_RD2; alu_sel = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU;
                ir_write  = (wait_q == WAIT_LAST);
                pc_upd    = (wait_q == WAIT_LAST);
            end
            S_DECODE: begin
                alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU;
            end
            S_MEMADR:   alu_src_b = SRCB_IMM;
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = RES_DATA; reg_w = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_w = 1'b1; end
            S_EXECUTER: begin alu_src_b = SRCB_RD2; alu_sel = dp_op; flag_we = 1'b1; end
            S_EXECUTEI: begin alu_src_b = SRCB_IMM; alu_sel = dp_op; flag_we = 1'b1; end
            S_ALUWB:    begin result_src = RES_ALUOUT; reg_w = 1'b1; end
            S_BRANCH:   begin alu_src_b = SRCB_IMM; result_src = RES_ALU; branch = 1'b1; end
            default: ;
        endcase
    end

    cond_unit u_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .Cond    (bus.Instr[31:28]),
        .Flags   (bus.Flags),
        .FlagW   (dp_flagw),
        .flag_we (flag_we),
        .CondEx  (cond_ex)
    );

    // Strobes are forced low while reset is held so nothing writes mid-reset.
    assign bus.PCWrite    = rst_n & (pc_upd | ((branch | (reg_w & (rd == 4'hF))) & cond_ex));
    assign bus.IRWrite    = rst_n & ir_write;
    assign bus.RegWrite   = rst_n & reg_w & cond_ex;
    assign bus.MemWrite   = rst_n & mem_w & cond_ex;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = ALUCTRL_W'(alu_sel);
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit: one MEM_WAIT=0 instance for the
// instruction mix and one MEM_WAIT=2 instance for the LDR wait-state timing.
module tb_multicycle_controlunit;
    import ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_controlunit_if #(.ALUCTRL_W(3)) bus0 ();
    multicycle_controlunit_if #(.ALUCTRL_W(3)) bus2 ();

    multicycle_controlunit #(.ALUCTRL_W(3), .MEM_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_controlunit #(.ALUCTRL_W(3), .MEM_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    // LDR with MEM_WAIT=2: FETCH x3, DECODE, MEMADR, MEMREAD x3, MEMWB.
    state_e     ldr_st [9] = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
                               S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    logic [8:0] ldr_irw = 9'b000000100;
    logic [8:0] ldr_rw  = 9'b100000000;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input state_e exp);
        check(tag, 32'(dut0.state_q), 32'(exp));
    endtask

    // Data-processing instruction, starting from its FETCH cycle.
    task automatic run_dp(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                          input alu_op_e exp_alu, input state_e exp_ex,
                          input logic exp_rw, input logic exp_pcw);
        bus0.Instr = ins;
        chk_state($sformatf("%s_fetch", tag), S_FETCH);
        check($sformatf("%s_irw", tag), 32'(bus0.IRWrite), 32'd1);
        step();
        chk_state($sformatf("%s_decode", tag), S_DECODE);
        step();
        chk_state($sformatf("%s_exec", tag), exp_ex);
        check($sformatf("%s_alu", tag), 32'(bus0.ALUControl), 32'(exp_alu));
        check($sformatf("%s_srcb", tag), 32'(bus0.ALUSrcB),
              (exp_ex == S_EXECUTEI) ? 32'd1 : 32'd0);
        check($sformatf("%s_rw_exec", tag), 32'(bus0.RegWrite), 32'd0);
        bus0.Flags = fl;
        step();
        chk_state($sformatf("%s_aluwb", tag), S_ALUWB);
        check($sformatf("%s_rw", tag), 32'(bus0.RegWrite), 32'(exp_rw));
        check($sformatf("%s_pcw", tag), 32'(bus0.PCWrite), 32'(exp_pcw));
        check($sformatf("%s_res", tag), 32'(bus0.ResultSrc), 32'd0);
        step();
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic exp_pcw);
        bus0.Instr = ins;
        chk_state($sformatf("%s_fetch", tag), S_FETCH);
        step();
        chk_state($sformatf("%s_decode", tag), S_DECODE);
        step();
        chk_state($sformatf("%s_branch", tag), S_BRANCH);
        check($sformatf("%s_pcw", tag), 32'(bus0.PCWrite), 32'(exp_pcw));
        check($sformatf("%s_regsrc", tag), 32'(bus0.RegSrc), 32'd1);
        step();
    endtask

    task automatic run_str(input string tag, input logic [31:0] ins, input logic exp_mw);
        bus0.Instr = ins;
        chk_state($sformatf("%s_fetch", tag), S_FETCH);
        step();
        chk_state($sformatf("%s_decode", tag), S_DECODE);
        step();
        chk_state($sformatf("%s_memadr", tag), S_MEMADR);
        check($sformatf("%s_srcb", tag), 32'(bus0.ALUSrcB), 32'd1);
        step();
        chk_state($sformatf("%s_memwrite", tag), S_MEMWRITE);
        check($sformatf("%s_mw", tag), 32'(bus0.MemWrite), 32'(exp_mw));
        check($sformatf("%s_adr", tag), 32'(bus0.AdrSrc), 32'd1);
        check($sformatf("%s_regsrc", tag), 32'(bus0.RegSrc), 32'd2);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.Instr = 32'hE0812003; bus0.Flags = '0;
        bus2.Instr = 32'hE5912004; bus2.Flags = '0;
        #12;
        check("rst_pcw", 32'(bus0.PCWrite), 32'd0);
        check("rst_irw", 32'(bus0.IRWrite), 32'd0);
        check("rst_srca", 32'(bus0.ALUSrcA), 32'd1);
        check("rst_srcb", 32'(bus0.ALUSrcB), 32'd2);
        check("rst_res", 32'(bus0.ResultSrc), 32'd2);

        // LDR timing on the MEM_WAIT=2 instance.
        @(negedge clk); rst_n = 1'b1; #1;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("ldr_state_c%0d", c + 1), 32'(dut2.state_q), 32'(ldr_st[c]));
            check($sformatf("ldr_irw_c%0d", c + 1), 32'(bus2.IRWrite), 32'(ldr_irw[c]));
            check($sformatf("ldr_rw_c%0d", c + 1), 32'(bus2.RegWrite), 32'(ldr_rw[c]));
            if (ldr_st[c] == S_MEMWB)
                check("ldr_memwb_res", 32'(bus2.ResultSrc), 32'd1);
            step();
        end
        check("ldr_next_fetch", 32'(dut2.state_q), 32'(S_FETCH));

        // Restart both instances for the MEM_WAIT=0 sequence.
        rst_n = 1'b0; #1;
        chk_state("rst2_state", S_FETCH);
        check("rst2_pcw", 32'(bus0.PCWrite), 32'd0);
        check("rst2_rw", 32'(bus0.RegWrite), 32'd0);
        check("rst2_mw", 32'(bus0.MemWrite), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;

        run_dp("add", 32'hE0812003, 4'b0000, ALU_ADD, S_EXECUTER, 1'b1, 1'b0);
        run_dp("subs_z", 32'hE0511001, 4'b0100, ALU_SUB, S_EXECUTER, 1'b1, 1'b0);
        run_br("beq_taken", 32'h0A000002, 1'b1);
        run_dp("subs_nz", 32'hE0511001, 4'b0000, ALU_SUB, S_EXECUTER, 1'b1, 1'b0);
        run_br("beq_not", 32'h0A000002, 1'b0);
        run_dp("subs_z2", 32'hE0511001, 4'b0100, ALU_SUB, S_EXECUTER, 1'b1, 1'b0);
        run_str("strne", 32'h15812000, 1'b0);
        run_str("str", 32'hE5812000, 1'b1);
        run_dp("orr_imm", 32'hE3812003, 4'b0000, ALU_ORR, S_EXECUTEI, 1'b1, 1'b0);
        run_dp("eor", 32'hE0212003, 4'b0000, ALU_EOR, S_EXECUTER, 1'b1, 1'b0);
        // ANDS writes only N,Z: C stays 0, so BCS falls through and BMI is taken.
        run_dp("ands", 32'hE0112003, 4'b1011, ALU_AND, S_EXECUTER, 1'b1, 1'b0);
        run_br("bcs_not", 32'h2A000002, 1'b0);
        run_br("bmi_taken", 32'h4A000002, 1'b1);
        run_dp("add_pc", 32'hE081F003, 4'b0000, ALU_ADD, S_EXECUTER, 1'b1, 1'b1);

        bus0.Instr = 32'hEC000000;
        chk_state("undef_fetch", S_FETCH);
        step();
        chk_state("undef_decode", S_DECODE);
        check("undef_strobes", 32'({bus0.PCWrite, bus0.IRWrite, bus0.RegWrite, bus0.MemWrite}), 32'd0);
        step();
        chk_state("undef_back", S_FETCH);

        // Set Z, then reset during the ALUWB of an ADD.
        run_dp("subs_z3", 32'hE0511001, 4'b0100, ALU_SUB, S_EXECUTER, 1'b1, 1'b0);
        bus0.Instr = 32'hE0812003;
        step(); step(); step();
        chk_state("rstwb_aluwb", S_ALUWB);
        check("rstwb_rw_before", 32'(bus0.RegWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwb_rw_after", 32'(bus0.RegWrite), 32'd0);
        chk_state("rstwb_state", S_FETCH);
        check("rstwb_pcw", 32'(bus0.PCWrite), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        run_br("beq_after_rst", 32'h0A000002, 1'b0);

        bus0.Instr = 32'hE1510002;
        step(); step();
        chk_state("cmp_exec", S_EXECUTER);
        check("cmp_rw_exec", 32'(bus0.RegWrite), 32'd0);
        bus0.Flags = 4'b0100;
`ifdef CTRL_CMP_TST_EN
        check("cmp_alu", 32'(bus0.ALUControl), 32'(ALU_SUB));
        step();
        chk_state("cmp_back", S_FETCH);
        check("cmp_rw_after", 32'(bus0.RegWrite), 32'd0);
        run_br("beq_after_cmp", 32'h0A000002, 1'b1);
`else
        check("cmp_alu", 32'(bus0.ALUControl), 32'(ALU_ADD));
        step();
        chk_state("cmp_aluwb", S_ALUWB);
        check("cmp_rw_wb", 32'(bus0.RegWrite), 32'd1);
        step();
        run_br("beq_after_cmp", 32'h0A000002, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
